// File: rtl/alu_result_serializer_pkg.sv
// Shared types and sizing helpers for the ALU result serializer.
// State encoding, byte width, and byte-count/counter-width functions.
package alu_result_serializer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEND    = 2'b01,
        WAIT_HI = 2'b10,
        WAIT_LO = 2'b11
    } ser_state_t;

    function automatic int nbytes(input int width);
        return width / BYTE_W;
    endfunction

    function automatic int cnt_width(input int width);
        int n;
        n = width / BYTE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_result_serializer_hold_buf.sv
// One-entry pending buffer between the ALU result bus and the serializer.
// Ports: clk, rst (async low), load/din (write), take (read), dout, full, drop.
module result_hold_buf
    import alu_result_serializer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             drop
);

    logic [WIDTH-1:0] pb;
    logic             pv;

    // A take in the same cycle frees the slot for the incoming word.
    assign drop = load && pv && !take;
    assign dout = pb;
    assign full = pv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb <= '0;
            pv <= 1'b0;
        end else if (load && (!pv || take)) begin
            pb <= din;
            pv <= 1'b1;
        end else if (take) begin
            pv <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_result_serializer.sv
// Streams WIDTH-bit ALU results to the UART TX byte by byte, LSB first.
// Ports: clk, rst, res_in/res_valid, tx_busy, ovf_clr -> tx_data/tx_valid, ready, active, overflow.
module alu_result_serializer
    import alu_result_serializer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] res_in,
    input  logic             res_valid,
    input  logic             tx_busy,
    input  logic             ovf_clr,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             ready,
    output logic             active,
    output logic             overflow
);

    localparam int NB = nbytes(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pb_data;
    logic             pv;
    logic             direct;
    logic             load;
    logic             take;
    logic             drop;

    assign direct = res_valid && (state == IDLE) && !pv;
    assign load   = res_valid && !direct;
    // PB drains into SR after the last byte, or from IDLE if a word
    // landed in PB on the very edge the FSM went idle.
    assign take   = pv && ((state == IDLE) ||
                    ((state == WAIT_LO) && !tx_busy && (cnt == CNT_LAST)));

    assign ready  = !pv;
    assign active = (state != IDLE);

    result_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .take (take),
        .din  (res_in),
        .dout (pb_data),
        .full (pv),
        .drop (drop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (direct) begin
                        sr    <= res_in;
                        cnt   <= '0;
                        state <= SEND;
                    end else if (take) begin
                        sr    <= pb_data;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_valid <= 1'b1;
                        tx_data  <= sr[BYTE_W-1:0];
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (cnt != CNT_LAST) begin
                            sr    <= sr >> BYTE_W;
                            cnt   <= cnt + 1'b1;
                            state <= SEND;
                        end else if (pv) begin
                            sr    <= pb_data;
                            cnt   <= '0;
                            state <= SEND;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Set wins over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Scoreboard bench for alu_result_serializer (WIDTH=16 and WIDTH=32).
// Expected bytes are queued at stimulus time and popped on each tx_valid.
module tb_alu_result_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] res_in16 = '0;
    logic        res_valid16 = 1'b0;
    logic        ovf_clr16 = 1'b0;
    logic        force_busy = 1'b0;
    logic        tx_busy16;
    logic [7:0]  tx_data16;
    logic        tx_valid16, ready16, active16, overflow16;

    logic [31:0] res_in32 = '0;
    logic        res_valid32 = 1'b0;
    logic        tx_busy32;
    logic [7:0]  tx_data32;
    logic        tx_valid32, ready32, active32, overflow32;

    int bc16 = 0;
    int bc32 = 0;
    int nvec = 0;
    int nerr = 0;
    logic [7:0] q16[$];
    logic [7:0] q32[$];

    alu_result_serializer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst_n), .res_in(res_in16), .res_valid(res_valid16),
        .tx_busy(tx_busy16), .ovf_clr(ovf_clr16), .tx_data(tx_data16),
        .tx_valid(tx_valid16), .ready(ready16), .active(active16),
        .overflow(overflow16)
    );

    alu_result_serializer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst_n), .res_in(res_in32), .res_valid(res_valid32),
        .tx_busy(tx_busy32), .ovf_clr(1'b0), .tx_data(tx_data32),
        .tx_valid(tx_valid32), .ready(ready32), .active(active32),
        .overflow(overflow32)
    );

    // UART TX models: busy for 10 cycles starting the cycle after a strobe.
    always @(posedge clk) begin
        if (tx_valid16) bc16 <= 10;
        else if (bc16 != 0) bc16 <= bc16 - 1;
        if (tx_valid32) bc32 <= 10;
        else if (bc32 != 0) bc32 <= bc32 - 1;
    end
    assign tx_busy16 = (bc16 != 0) || force_busy;
    assign tx_busy32 = (bc32 != 0);

    // Monitors
    always @(negedge clk) begin
        if (rst_n && tx_valid16) begin
            nvec++;
            if (q16.size() == 0) begin
                nerr++;
                $display("FAIL mon16: unexpected byte %h", tx_data16);
            end else begin
                logic [7:0] e;
                e = q16.pop_front();
                if (tx_data16 !== e) begin
                    nerr++;
                    $display("FAIL mon16: got %h expected %h", tx_data16, e);
                end
            end
        end
        if (rst_n && tx_valid32) begin
            nvec++;
            if (q32.size() == 0) begin
                nerr++;
                $display("FAIL mon32: unexpected byte %h", tx_data32);
            end else begin
                logic [7:0] e;
                e = q32.pop_front();
                if (tx_data32 !== e) begin
                    nerr++;
                    $display("FAIL mon32: got %h expected %h", tx_data32, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse16(input logic [15:0] d, input bit push);
        @(negedge clk);
        res_in16 = d;
        res_valid16 = 1'b1;
        if (push) begin
            q16.push_back(d[7:0]);
            q16.push_back(d[15:8]);
        end
        @(negedge clk);
        res_valid16 = 1'b0;
    endtask

    task automatic wait_idle16(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!active16 && q16.size() == 0) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n;
        bit seen;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_data", {24'd0, tx_data16}, 32'h00);
        chk("rst_tx_valid", {31'd0, tx_valid16}, 32'd0);
        chk("rst_ready", {31'd0, ready16}, 32'd1);
        chk("rst_active", {31'd0, active16}, 32'd0);
        chk("rst_overflow", {31'd0, overflow16}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, strobe latency
        pulse16(16'hA55A, 1'b1);
        chk("t1_valid_k", {31'd0, tx_valid16}, 32'd0);
        chk("t1_active", {31'd0, active16}, 32'd1);
        chk("t1_ready", {31'd0, ready16}, 32'd1);
        @(negedge clk);
        chk("t1_valid_k1", {31'd0, tx_valid16}, 32'd1);
        wait_idle16("t1_idle");
        chk("t1_ready_end", {31'd0, ready16}, 32'd1);

        // Back-to-back
        pulse16(16'h0003, 1'b1);
        pulse16(16'h1234, 1'b1);
        chk("t2_ready_pb", {31'd0, ready16}, 32'd0);
        wait_idle16("t2_idle");
        chk("t2_overflow", {31'd0, overflow16}, 32'd0);
        chk("t2_ready_end", {31'd0, ready16}, 32'd1);

        // Overflow
        pulse16(16'h1111, 1'b1);
        pulse16(16'h2222, 1'b1);
        pulse16(16'h3333, 1'b0);
        chk("t3_ovf_set", {31'd0, overflow16}, 32'd1);
        @(negedge clk);
        ovf_clr16 = 1'b1;
        @(negedge clk);
        ovf_clr16 = 1'b0;
        chk("t3_ovf_clr", {31'd0, overflow16}, 32'd0);
        @(negedge clk);
        res_in16 = 16'h4444;
        res_valid16 = 1'b1;
        ovf_clr16 = 1'b1;
        @(negedge clk);
        res_valid16 = 1'b0;
        ovf_clr16 = 1'b0;
        chk("t3_set_wins", {31'd0, overflow16}, 32'd1);
        @(negedge clk);
        ovf_clr16 = 1'b1;
        @(negedge clk);
        ovf_clr16 = 1'b0;
        chk("t3_ovf_clr2", {31'd0, overflow16}, 32'd0);
        wait_idle16("t3_idle");

        // TX busy at start
        force_busy = 1'b1;
        pulse16(16'h5678, 1'b1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_valid16) n++;
        end
        chk("t4_no_strobe", n, 0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("t4_strobe_after", {31'd0, tx_valid16}, 32'd1);
        wait_idle16("t4_idle");

        // Reset mid-word (in WAIT_LO after byte 0)
        pulse16(16'hBEEF, 1'b0);
        q16.push_back(8'hEF);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bc16 != 0) seen = 1'b1;
        end
        chk("t5_busy_seen", {31'd0, seen}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_tx_data", {24'd0, tx_data16}, 32'h00);
        chk("t5_tx_valid", {31'd0, tx_valid16}, 32'd0);
        chk("t5_ready", {31'd0, ready16}, 32'd1);
        chk("t5_active", {31'd0, active16}, 32'd0);
        chk("t5_overflow", {31'd0, overflow16}, 32'd0);
        chk("t5_q_drained", q16.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_valid16 || active16) n++;
        end
        chk("t5_quiet", n, 0);
        pulse16(16'h00C3, 1'b1);
        wait_idle16("t5_idle");

        // WIDTH=32
        @(negedge clk);
        res_in32 = 32'h01020304;
        res_valid32 = 1'b1;
        q32.push_back(8'h04);
        q32.push_back(8'h03);
        q32.push_back(8'h02);
        q32.push_back(8'h01);
        @(negedge clk);
        res_valid32 = 1'b0;
        chk("t6_active", {31'd0, active32}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (!active32 && q32.size() == 0) seen = 1'b1;
        end
        chk("t6_idle", {31'd0, seen}, 32'd1);
        chk("t6_cnt_wrap", {30'd0, dut32.cnt}, 32'd0);
        chk("t6_overflow", {31'd0, overflow32}, 32'd0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
